// File: rtl/dmem_access_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// load/store controller (slave).
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for the byte-wide data memory. One request in flight at
// a time; memory strobes are registered and exactly one cycle wide. Bad
// requests raise a sticky error that remembers the first offending address.
module dmem_access_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 64,
    parameter int TAG_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    dmem_access_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data_M,
    output logic              write_en,
    output logic              read_en,
    output logic [2:0]        opcode,
    input  logic [DATA_W-1:0] read_data,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        ld_cnt,
    output logic [7:0]        st_cnt
);
    localparam logic [2:0]      OP_LOAD  = 3'b000;
    localparam logic [2:0]      OP_STORE = 3'b001;
    localparam logic [2:0]      OP_NONE  = 3'b111;
    localparam logic [ADDR_W:0] DEPTH    = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_RESP} state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              wen_q,      wen_d;
    logic              ren_q,      ren_d;
    logic [2:0]        opc_q,      opc_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q,  rsp_tag_d;
    logic [TAG_W-1:0]  tag_q,      tag_d;
    logic              err_q,      err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [7:0]        ld_cnt_q,   ld_cnt_d;
    logic [7:0]        st_cnt_q,   st_cnt_d;

    logic in_range;
    assign in_range = ({1'b0, bus.req_addr} < DEPTH);

    // Control and memory-side registers; reset drops strobes immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            opc_q      <= OP_NONE;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            ld_cnt_q   <= '0;
            st_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            opc_q      <= opc_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            ld_cnt_q   <= ld_cnt_d;
            st_cnt_q   <= st_cnt_d;
        end
    end

    // Load tag is pure payload carried to the response; no reset needed.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    // Next-state logic; strobes for the next cycle are decided here so the
    // registered pins line up exactly with the LOAD/STORE states.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wen_d      = 1'b0;
        ren_d      = 1'b0;
        opc_d      = OP_NONE;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        tag_d      = tag_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        ld_cnt_d   = ld_cnt_q;
        st_cnt_d   = st_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op == OP_LOAD && in_range) begin
                        state_d = S_LOAD;
                        addr_d  = bus.req_addr;
                        tag_d   = bus.req_tag;
                        ren_d   = 1'b1;
                        opc_d   = OP_LOAD;
                    end else if (bus.req_op == OP_STORE && in_range) begin
                        state_d = S_STORE;
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                        wen_d   = 1'b1;
                        opc_d   = OP_STORE;
                    end else begin
                        // Only the first bad request is remembered.
                        if (!err_q) begin
                            err_d      = 1'b1;
                            err_addr_d = bus.req_addr;
                        end
                        // A bad load still owes writeback a (zero) response.
                        if (bus.req_op == OP_LOAD) begin
                            state_d    = S_RESP;
                            rsp_data_d = '0;
                            rsp_tag_d  = bus.req_tag;
                        end
                    end
                end
            end
            S_LOAD: begin
                rsp_data_d = read_data;
                rsp_tag_d  = tag_q;
                ld_cnt_d   = ld_cnt_q + 8'd1;
                state_d    = S_RESP;
            end
            S_STORE: begin
                st_cnt_d = st_cnt_q + 8'd1;
                state_d  = S_IDLE;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign mem_addr      = addr_q;
    assign write_data_M  = wdata_q;
    assign write_en      = wen_q;
    assign read_en       = ren_q;
    assign opcode        = opc_q;
    assign err           = err_q;
    assign err_addr      = err_addr_q;
    assign ld_cnt        = ld_cnt_q;
    assign st_cnt        = st_cnt_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural memory, table of directed
// transactions, hand-written multi-cycle sequences and a randomized run
// against a transaction-level reference model.
module tb_dmem_access_ctrl;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    logic [7:0] mem_addr, write_data_M, read_data, err_addr, ld_cnt, st_cnt;
    logic       write_en, read_en, err;
    logic [2:0] opcode;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(64), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .mem_addr(mem_addr), .write_data_M(write_data_M), .write_en(write_en),
        .read_en(read_en), .opcode(opcode), .read_data(read_data),
        .err(err), .err_addr(err_addr), .ld_cnt(ld_cnt), .st_cnt(st_cnt)
    );

    // Memory: power-up contents are 0xEC+addr; write_en with a non-store
    // opcode zeroes the location, as the real part does.
    function automatic logic [7:0] init_val(input logic [7:0] a);
        return 8'hEC + a;
    endfunction

    bit         written [64];
    logic [7:0] wmem    [64];
    always @(posedge clk) begin
        if (write_en && mem_addr < 8'd64) begin
            written[mem_addr[5:0]] <= 1'b1;
            wmem[mem_addr[5:0]]    <= (opcode == 3'b001) ? write_data_M : 8'h00;
        end
    end
    assign read_data = (mem_addr < 8'd64) ?
        (written[mem_addr[5:0]] ? wmem[mem_addr[5:0]] : init_val(mem_addr)) : 8'h00;

    // Strobe monitor: cycles with each strobe high, and protocol violations.
    int rd_cyc = 0, wr_cyc = 0, viol = 0;
    always @(negedge clk) begin
        if (read_en)  rd_cyc <= rd_cyc + 1;
        if (write_en) wr_cyc <= wr_cyc + 1;
        if ((write_en && opcode != 3'b001) || (read_en && opcode != 3'b000) || (write_en && read_en))
            viol <= viol + 1;
    end

    int nvec = 0, nmis = 0;

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s %s: got %0h required %0h", nm, what, act, exp);
        end
    endtask

    // Reference model: memory image, sticky error and counters.
    logic [7:0] ref_mem [64];
    logic       m_err;
    logic [7:0] m_ea, m_ld, m_st;

    task automatic model_reset();
        m_err = 1'b0; m_ea = 8'h00; m_ld = 8'h00; m_st = 8'h00;
    endtask

    task automatic model_step(input logic [2:0] op, input logic [7:0] a, input logic [7:0] wd,
                              output bit e_rsp, output logic [7:0] e_d, output int e_rd, output int e_wr);
        bit inr;
        bit bad;
        inr = (a < 8'd64);
        e_rsp = 1'b0; e_d = 8'h00; e_rd = 0; e_wr = 0;
        bad = 1'b0;
        if (op == 3'b000) begin
            e_rsp = 1'b1;
            if (inr) begin
                e_d = ref_mem[a[5:0]]; e_rd = 1; m_ld = m_ld + 8'd1;
            end else bad = 1'b1;
        end else if (op == 3'b001) begin
            if (inr) begin
                ref_mem[a[5:0]] = wd; e_wr = 1; m_st = m_st + 8'd1;
            end else bad = 1'b1;
        end else bad = 1'b1;
        if (bad && !m_err) begin
            m_err = 1'b1; m_ea = a;
        end
    endtask

    // Issue one request from a negedge and follow it until the controller is idle again.
    task automatic apply(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] wd,
                         input logic [2:0] tag, input bit x_rsp, input logic [7:0] x_d, input logic x_e,
                         input logic [7:0] x_ea, input logic [7:0] x_ld, input logic [7:0] x_st,
                         input int x_rd, input int x_wr);
        bit got; logic [7:0] d; logic [2:0] t; int n, rd0, wr0;
        got = 1'b0; d = 8'h00; t = 3'd0; n = 0;
        rd0 = rd_cyc; wr0 = wr_cyc;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk); n++;
        end
        chk(nm, "ready before request", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd; bus.req_tag = tag;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            if (bus.rsp_valid && !got) begin
                got = 1'b1; d = bus.rsp_data; t = bus.rsp_tag;
            end
            @(negedge clk); n++;
        end
        chk(nm, "completes", 32'(bus.req_ready), 32'd1);
        chk(nm, "response seen", 32'(got), 32'(x_rsp));
        if (x_rsp) begin
            chk(nm, "rsp_data", 32'(d), 32'(x_d));
            chk(nm, "rsp_tag", 32'(t), 32'(tag));
        end
        chk(nm, "err", 32'(err), 32'(x_e));
        chk(nm, "err_addr", 32'(err_addr), 32'(x_ea));
        chk(nm, "ld_cnt", 32'(ld_cnt), 32'(x_ld));
        chk(nm, "st_cnt", 32'(st_cnt), 32'(x_st));
        chk(nm, "read_en cycles", 32'(rd_cyc - rd0), 32'(x_rd));
        chk(nm, "write_en cycles", 32'(wr_cyc - wr0), 32'(x_wr));
    endtask

    typedef struct {
        logic [2:0] op; logic [7:0] addr; logic [7:0] wd; logic [2:0] tag;
        bit rsp; logic [7:0] d; logic e; logic [7:0] ea; logic [7:0] ld; logic [7:0] st;
        int rd; int wr;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        bit e_rsp; logic [7:0] e_d; int e_rd, e_wr, rd0, wr0;
        logic [2:0] op; logic [7:0] a, wd; logic [2:0] tag;

        tbl[0] = '{3'b000, 8'h01, 8'h00, 3'd5, 1'b1, 8'hED, 1'b0, 8'h00, 8'd1, 8'd0, 1, 0};
        tbl[1] = '{3'b001, 8'h0A, 8'h5A, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd1, 8'd1, 0, 1};
        tbl[2] = '{3'b000, 8'h0A, 8'h00, 3'd2, 1'b1, 8'h5A, 1'b0, 8'h00, 8'd2, 8'd1, 1, 0};
        tbl[3] = '{3'b001, 8'h50, 8'h11, 3'd0, 1'b0, 8'h00, 1'b1, 8'h50, 8'd2, 8'd1, 0, 0};
        tbl[4] = '{3'b000, 8'h41, 8'h00, 3'd7, 1'b1, 8'h00, 1'b1, 8'h50, 8'd2, 8'd1, 0, 0};
        tbl[5] = '{3'b010, 8'h02, 8'h33, 3'd0, 1'b0, 8'h00, 1'b1, 8'h50, 8'd2, 8'd1, 0, 0};
        tbl[6] = '{3'b000, 8'h02, 8'h00, 3'd1, 1'b1, 8'hEE, 1'b1, 8'h50, 8'd3, 8'd1, 1, 0};
        tbl[7] = '{3'b101, 8'h05, 8'hFF, 3'd0, 1'b0, 8'h00, 1'b1, 8'h50, 8'd3, 8'd1, 0, 0};
        tbl[8] = '{3'b000, 8'h05, 8'h00, 3'd3, 1'b1, 8'hF1, 1'b1, 8'h50, 8'd4, 8'd1, 1, 0};

        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(8'(i));
        model_reset();

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 3'b000; bus.req_addr = 8'h00;
        bus.req_wdata = 8'h00; bus.req_tag = 3'd0; bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("reset", "req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset", "rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("reset", "rsp_tag", 32'(bus.rsp_tag), 32'd0);
        chk("reset", "mem_addr", 32'(mem_addr), 32'd0);
        chk("reset", "write_data_M", 32'(write_data_M), 32'd0);
        chk("reset", "write_en", 32'(write_en), 32'd0);
        chk("reset", "read_en", 32'(read_en), 32'd0);
        chk("reset", "opcode", 32'(opcode), 32'd7);
        chk("reset", "err", 32'(err), 32'd0);
        chk("reset", "err_addr", 32'(err_addr), 32'd0);
        chk("reset", "ld_cnt", 32'(ld_cnt), 32'd0);
        chk("reset", "st_cnt", 32'(st_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            model_step(tbl[i].op, tbl[i].addr, tbl[i].wd, e_rsp, e_d, e_rd, e_wr);
            apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].tag,
                  tbl[i].rsp, tbl[i].d, tbl[i].e, tbl[i].ea, tbl[i].ld, tbl[i].st, tbl[i].rd, tbl[i].wr);
        end

        // Back-pressure: load addr 3 with rsp_ready low for 4 response cycles
        bus.rsp_ready = 1'b0;
        model_step(3'b000, 8'h03, 8'h00, e_rsp, e_d, e_rd, e_wr);
        rd0 = rd_cyc;
        bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.req_addr = 8'h03; bus.req_tag = 3'd4;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp", "read_en", 32'(read_en), 32'd1);
        chk("bp", "opcode in load", 32'(opcode), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp", "rsp_valid held", 32'(bus.rsp_valid), 32'd1);
            chk("bp", "rsp_data held", 32'(bus.rsp_data), 32'(e_d));
            chk("bp", "rsp_tag held", 32'(bus.rsp_tag), 32'd4);
            chk("bp", "req_ready low", 32'(bus.req_ready), 32'd0);
            if (i == 4) bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("bp", "rsp_valid released", 32'(bus.rsp_valid), 32'd0);
        chk("bp", "req_ready back", 32'(bus.req_ready), 32'd1);
        chk("bp", "single read pulse", 32'(rd_cyc - rd0), 32'd1);
        chk("bp", "ld_cnt", 32'(ld_cnt), 32'(m_ld));

        // Store: strobe and req_ready low for exactly one cycle
        model_step(3'b001, 8'h0C, 8'h3C, e_rsp, e_d, e_rd, e_wr);
        bus.req_valid = 1'b1; bus.req_op = 3'b001; bus.req_addr = 8'h0C; bus.req_wdata = 8'h3C;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("st", "req_ready low", 32'(bus.req_ready), 32'd0);
        chk("st", "write_en", 32'(write_en), 32'd1);
        chk("st", "opcode", 32'(opcode), 32'd1);
        chk("st", "write_data_M", 32'(write_data_M), 32'h3C);
        chk("st", "mem_addr", 32'(mem_addr), 32'h0C);
        @(negedge clk);
        chk("st", "req_ready back", 32'(bus.req_ready), 32'd1);
        chk("st", "write_en dropped", 32'(write_en), 32'd0);
        chk("st", "opcode idle", 32'(opcode), 32'd7);
        chk("st", "st_cnt", 32'(st_cnt), 32'(m_st));

        // Reset asserted during a STORE cycle: no write, everything back to reset values
        bus.req_valid = 1'b1; bus.req_op = 3'b001; bus.req_addr = 8'h15; bus.req_wdata = 8'h99;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_st", "write_en before reset", 32'(write_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_st", "write_en", 32'(write_en), 32'd0);
        chk("rst_st", "opcode", 32'(opcode), 32'd7);
        chk("rst_st", "mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_st", "req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_st", "err", 32'(err), 32'd0);
        chk("rst_st", "st_cnt", 32'(st_cnt), 32'd0);
        chk("rst_st", "ld_cnt", 32'(ld_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        model_step(3'b000, 8'h15, 8'h00, e_rsp, e_d, e_rd, e_wr);
        apply("rst_st_reload", 3'b000, 8'h15, 8'h00, 3'd6, e_rsp, e_d, m_err, m_ea, m_ld, m_st, e_rd, e_wr);

        // Randomized run against the reference model
        for (int k = 0; k < 700; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45)      op = 3'b000;
            else if (r < 90) op = 3'b001;
            else             op = 3'($urandom_range(2, 7));
            if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(64, 255));
            else                           a = 8'($urandom_range(0, 63));
            wd  = 8'($urandom_range(0, 255));
            tag = 3'($urandom_range(0, 7));
            model_step(op, a, wd, e_rsp, e_d, e_rd, e_wr);
            apply($sformatf("rnd%0d", k), op, a, wd, tag, e_rsp, e_d, m_err, m_ea, m_ld, m_st, e_rd, e_wr);
        end

        chk("monitor", "strobe/opcode violations", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
